// File: rtl/fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe
// Purpose  : Instruction fetch (PC owner) plus IF/ID pipeline register for the
//            16-bit ThinPad CPU, with branch redirect and stall handling.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pipe #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcKeep,
    input  logic        ifKeep,
    input  logic        ifClear,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    input  logic        memBusy,
    input  logic [15:0] instrIn,
    output logic [15:0] fetchAddr,
    output logic        fetchEn,
    output logic [15:0] idPc,
    output logic [15:0] idInstr,
    output logic        idValid,
    output logic [15:0] stallCnt,
    output logic [15:0] squashCnt
);

    localparam logic [15:0] c_cntMax = 16'hFFFF;

    logic [15:0] r_pc;
    logic [15:0] r_idPc;
    logic [15:0] r_idInstr;
    logic        r_idValid;
    logic        r_redirPend;
    logic [15:0] r_redirAddr;
    logic [15:0] r_stallCnt;
    logic [15:0] r_squashCnt;

    logic        w_redir;
    logic [15:0] w_target;
    logic [15:0] w_pcInc;
    logic        w_bubble;
    logic        w_stall;

    // A fresh branch from ID always overrides a redirect deferred by pcKeep.
    assign w_redir  = branchTaken || r_redirPend;
    assign w_target = branchTaken ? branchTarget : r_redirAddr;
    assign w_pcInc  = r_pc + 16'd1;
    assign w_bubble = !ifKeep && (ifClear || w_redir || memBusy || pcKeep);
    assign w_stall  = pcKeep || (memBusy && !w_redir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_redirPend <= 1'b0;
            r_redirAddr <= 16'h0000;
        end else if (pcKeep) begin
            if (branchTaken) begin
                r_redirPend <= 1'b1;
                r_redirAddr <= branchTarget;
            end
        end else if (w_redir) begin
            r_pc        <= w_target;
            r_redirPend <= 1'b0;
        end else if (!memBusy) begin
            r_pc <= w_pcInc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idInstr <= NOP;
            r_idPc    <= 16'h0000;
            r_idValid <= 1'b0;
        end else if (ifKeep) begin
            r_idInstr <= r_idInstr;
        end else if (w_bubble) begin
            r_idInstr <= NOP;
            r_idValid <= 1'b0;
        end else begin
            r_idInstr <= instrIn;
            r_idPc    <= w_pcInc;
            r_idValid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt  <= 16'h0000;
            r_squashCnt <= 16'h0000;
        end else begin
            if (w_stall && (r_stallCnt != c_cntMax)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (w_bubble && (r_squashCnt != c_cntMax)) begin
                r_squashCnt <= r_squashCnt + 16'd1;
            end
        end
    end

    assign fetchAddr = r_pc;
    assign fetchEn   = !memBusy && !rst;
    assign idPc      = r_idPc;
    assign idInstr   = r_idInstr;
    assign idValid   = r_idValid;
    assign stallCnt  = r_stallCnt;
    assign squashCnt = r_squashCnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pipe
// Purpose  : Directed plus randomized bench for fetch_pipe against a
//            behavioural model of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pipe;

    localparam logic [15:0] c_resetPc = 16'h0000;
    localparam logic [15:0] c_nop     = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcKeep;
    logic        ifKeep;
    logic        ifClear;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        memBusy;
    logic [15:0] instrIn;
    logic [15:0] fetchAddr;
    logic        fetchEn;
    logic [15:0] idPc;
    logic [15:0] idInstr;
    logic        idValid;
    logic [15:0] stallCnt;
    logic [15:0] squashCnt;

    int errors = 0;
    int checks = 0;

    // Reference state
    int mPc, mIdPc, mIdInstr, mRedirAddr, mStall, mSquash;
    bit mIdValid, mPend;

    fetch_pipe #(.RESET_PC(c_resetPc), .NOP(c_nop)) dut (
        .clk(clk), .rst(rst), .pcKeep(pcKeep), .ifKeep(ifKeep),
        .ifClear(ifClear), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .memBusy(memBusy), .instrIn(instrIn),
        .fetchAddr(fetchAddr), .fetchEn(fetchEn), .idPc(idPc),
        .idInstr(idInstr), .idValid(idValid), .stallCnt(stallCnt),
        .squashCnt(squashCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // One clock: drive inputs, check combinational outputs, clock, advance
    // the model by the fetch-stage rules, then compare registered outputs.
    task automatic step(input bit r, input bit pk, input bit ik, input bit ic,
                        input bit bt, input logic [15:0] tgt, input bit mb);
        int instr;
        bit redir, bubble;
        int target;
        instr        = (mPc ^ 16'hA5A5) & 16'hFFFF;
        rst          = r;
        pcKeep       = pk;
        ifKeep       = ik;
        ifClear      = ic;
        branchTaken  = bt;
        branchTarget = tgt;
        memBusy      = mb;
        instrIn      = 16'(instr);
        #1;
        chk("fetchEn", {15'd0, fetchEn}, {15'd0, !mb && !r});
        @(posedge clk);
        #1;
        if (r) begin
            mPc = c_resetPc; mIdInstr = c_nop; mIdPc = 0; mIdValid = 0;
            mPend = 0; mStall = 0; mSquash = 0;
        end else begin
            redir  = bt || mPend;
            target = bt ? tgt : mRedirAddr;
            bubble = !ik && (ic || redir || mb || pk);
            if (pk || (mb && !redir)) mStall = sat(mStall);
            if (bubble) mSquash = sat(mSquash);
            if (!ik) begin
                if (bubble) begin
                    mIdInstr = c_nop; mIdValid = 0;
                end else begin
                    mIdInstr = instr; mIdPc = (mPc + 1) % 65536; mIdValid = 1;
                end
            end
            if (pk) begin
                if (bt) begin mPend = 1; mRedirAddr = tgt; end
            end else if (redir) begin
                mPc = target; mPend = 0;
            end else if (!mb) begin
                mPc = (mPc + 1) % 65536;
            end
        end
        chk("fetchAddr", fetchAddr, 16'(mPc));
        chk("idInstr",   idInstr,   16'(mIdInstr));
        chk("idPc",      idPc,      16'(mIdPc));
        chk("idValid",   {15'd0, idValid}, {15'd0, mIdValid});
        chk("stallCnt",  stallCnt,  16'(mStall));
        chk("squashCnt", squashCnt, 16'(mSquash));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    initial begin
        mPc = 0; mIdPc = 0; mIdInstr = c_nop; mRedirAddr = 0;
        mStall = 0; mSquash = 0; mIdValid = 0; mPend = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        chk("rst_fetchAddr", fetchAddr, c_resetPc);
        chk("rst_idInstr", idInstr, c_nop);
        chk("rst_idValid", {15'd0, idValid}, 16'd0);

        // Reset then run
        run(1);
        chk("run_pc1", fetchAddr, 16'h0001);
        chk("run_instr0", idInstr, 16'hA5A5);
        chk("run_valid", {15'd0, idValid}, 16'd1);
        run(4);
        chk("run_pc5", fetchAddr, 16'h0005);

        // Load-use stall at PC=5
        step(0, 1, 1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 0, 0, 16'h0, 0);
        chk("stall_pc", fetchAddr, 16'h0005);
        chk("stall_instr", idInstr, 16'h0004 ^ 16'hA5A5);
        chk("stall_cnt", stallCnt, 16'd2);
        chk("stall_sq", squashCnt, 16'd0);
        run(1);
        chk("stall_after", fetchAddr, 16'h0006);
        run(2);

        // Branch at PC=8
        chk("br_pc8", fetchAddr, 16'h0008);
        step(0, 0, 0, 0, 1, 16'h0040, 0);
        chk("br_target", fetchAddr, 16'h0040);
        chk("br_nop", idInstr, c_nop);
        chk("br_sq", squashCnt, 16'd1);
        run(1);
        chk("br_instr", idInstr, 16'h0040 ^ 16'hA5A5);

        // Branch during stall
        step(0, 1, 0, 0, 1, 16'h0100, 0);
        step(0, 1, 0, 0, 0, 16'h0, 0);
        chk("brst_hold", fetchAddr, 16'h0041);
        step(0, 0, 0, 0, 0, 16'h0, 0);
        chk("brst_load", fetchAddr, 16'h0100);

        // memBusy for 3 cycles
        step(1, 0, 0, 0, 0, 16'h0, 0);
        run(3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 16'h0, 1);
        chk("mb_pc", fetchAddr, 16'h0003);
        chk("mb_stall", stallCnt, 16'd3);
        chk("mb_sq", squashCnt, 16'd3);
        run(2);
        step(0, 0, 1, 1, 0, 16'h0, 0);
        chk("keep_over_clear", idInstr, 16'h0004 ^ 16'hA5A5);

        // Randomized traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, 16'($urandom), $urandom_range(0, 4) == 0);
        end

        // PC wrap
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 0, 1, 16'hFFFF, 0);
        run(1);
        chk("wrap_pc", fetchAddr, 16'h0000);
        chk("wrap_idPc", idPc, 16'h0000);

        // Counter saturation
        step(1, 0, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 0, 16'h0, 0);
        chk("sat_stall", stallCnt, 16'hFFFF);
        chk("sat_squash", squashCnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
